// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, issues one word request
// at a time to instruction memory, and buffers each returned instruction in
// an IF/ID output register (with a one-entry hold register behind it for
// responses that arrive while decode is stalled). Redirects kill any fetch
// that is still in flight.
module fetch_stage #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    // instruction memory request channel
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    // instruction memory response channel
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    // control from decode / execute
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    // IF/ID register
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // one dead cycle after reset release
        REQ  = 2'd1,  // request presented, waiting for acceptance
        WAIT = 2'd2,  // request accepted, waiting for the response
        HOLD = 2'd3   // response parked in the hold register behind a stall
    } state_t;

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'd4};

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic            kill;        // the outstanding response belongs to a squashed fetch
    logic [31:0]     hold_instr;
    logic [XLEN-1:0] hold_pc;

    // per-cycle control decoded from state and inputs
    logic            out_free;
    logic            rsp_live;
    logic            load_rsp;
    logic            cap_hold;
    logic            load_hold;
    logic            pc_step;
    logic            set_kill;
    logic            clr_kill;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc & WORD_MASK;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; blocking
            // here would let later always_ff blocks see the updated state.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // (an unassigned path in always_comb infers a latch).
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ:  if (imem_req_ready) state_next = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid || kill || out_free) state_next = REQ;
                    else                                    state_next = HOLD;
                end
            end
            HOLD: if (redirect_valid || !stall) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath-control decode (Mealy: depends on state and inputs).
    always_comb begin
        imem_req_valid = (state == REQ);
        out_free       = !instr_valid || !stall;
        rsp_live       = (state == WAIT) && imem_rsp_valid && !kill;
        // a same-cycle redirect overrides any load or capture
        load_rsp       = rsp_live && out_free  && !redirect_valid;
        cap_hold       = rsp_live && !out_free && !redirect_valid;
        load_hold      = (state == HOLD) && !stall && !redirect_valid;
        pc_step        = load_rsp || cap_hold;
        // redirect with a request still out: its response must be dropped
        set_kill       = redirect_valid &&
                         (((state == REQ)  && imem_req_ready) ||
                          ((state == WAIT) && !imem_rsp_valid));
        // any response in WAIT retires the outstanding request
        clr_kill       = (state == WAIT) && imem_rsp_valid;
    end

    // PC and kill flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc   <= RESET_PC;
            kill <= 1'b0;
        end else begin
            if (redirect_valid) pc <= redirect_target;
            else if (pc_step)   pc <= pc + FOUR;   // wraps modulo 2^XLEN

            if (set_kill)      kill <= 1'b1;
            else if (clr_kill) kill <= 1'b0;
        end
    end

    // IF/ID output register: redirect flush, load, consume, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
        end else if (load_rsp) begin
            instr_valid <= 1'b1;
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
        end else if (load_hold) begin
            instr_valid <= 1'b1;
            instr       <= hold_instr;
            instr_pc    <= hold_pc;
        end else if (!stall) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
        end
    end

    // Hold register: parks a response that arrives while decode is stalled.
    // NOTE: deliberately not reset; it is only read in HOLD, which can only be
    // entered after a capture, so its power-up contents never escape.
    always_ff @(posedge clk) begin
        if (cap_hold) begin
            hold_instr <= imem_rsp_data;
            hold_pc    <= pc;
        end
    end

    assign imem_addr = pc & WORD_MASK;
    assign pc_plus4  = instr_pc + FOUR;
    assign op        = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7b5  = instr[30];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A memory model answers
// accepted requests after a programmable latency; tests push expected request
// addresses and expected delivered instructions, and monitors pop and compare.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr, instr_pc, pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;

    // wrap DUT (RESET_PC = 0xFFFF_FFFC), driven directly
    logic        reset_w;
    logic        req_valid_w, req_ready_w;
    logic [31:0] addr_w;
    logic        rsp_valid_w;
    logic [31:0] rsp_data_w;
    logic        stall_w, redirect_w;
    logic [31:0] redirect_pc_w;
    logic        instr_valid_w;
    logic [31:0] instr_w, instr_pc_w, pc_plus4_w;
    logic [6:0]  op_w;
    logic [2:0]  funct3_w;
    logic        funct7b5_w;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .pc_plus4(pc_plus4), .op(op), .funct3(funct3), .funct7b5(funct7b5)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset_w),
        .imem_req_valid(req_valid_w), .imem_req_ready(req_ready_w),
        .imem_addr(addr_w),
        .imem_rsp_valid(rsp_valid_w), .imem_rsp_data(rsp_data_w),
        .stall(stall_w), .redirect_valid(redirect_w), .redirect_pc(redirect_pc_w),
        .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w),
        .pc_plus4(pc_plus4_w), .op(op_w), .funct3(funct3_w), .funct7b5(funct7b5_w)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic [31:0] req_q[$];
    exp_t        del_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int budget   = 0;   // requests the memory model will still accept
    int rsp_lat  = 1;   // cycles from acceptance to response
    int accept_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0050_0093;
            32'h4: return 32'h00A0_0113;
            32'h8: return 32'h00C0_0193;
            32'hC: return 32'h40B5_0533;
            default: return {a[24:0], 7'h13};
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.word = mem_word(a);
        return e;
    endfunction

    // inputs are driven 2 time units after the falling edge
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_accept(input int base);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (accept_cnt > base) seen = 1'b1;
        end
        if (!seen) check("accept_timeout", accept_cnt, base + 1);
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (instr_valid) seen = 1'b1;
        end
        if (!seen) check("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    // Memory model: sees a pending acceptance at the falling edge, drops
    // ready after the accepting edge, answers rsp_lat cycles later.
    initial begin
        logic [31:0] a;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_req_ready = (budget > 0);
            if (!reset && imem_req_valid && imem_req_ready) begin
                a = imem_addr;
                if (req_q.size() > 0) check("req_addr", a, req_q.pop_front());
                else                  check("req_expected_count", req_q.size(), 1);
                budget--;
                accept_cnt++;
                @(negedge clk);
                imem_req_ready = 1'b0;
                repeat (rsp_lat - 1) @(negedge clk);
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(a);
            end
        end
    end

    // Delivery monitor: an instruction is consumed on an edge with
    // instr_valid=1, stall=0 and no redirect; sampled just before that edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && instr_valid && !stall && !redirect_valid) begin
                if (del_q.size() > 0) begin
                    e = del_q.pop_front();
                    check("instr",    instr,          e.word);
                    check("instr_pc", instr_pc,       e.pc);
                    check("pc_plus4", pc_plus4,       e.pc + 32'd4);
                    check("op",       32'(op),        32'(e.word[6:0]));
                    check("funct3",   32'(funct3),    32'(e.word[14:12]));
                    check("funct7b5", 32'(funct7b5),  32'(e.word[30]));
                end else begin
                    check("del_expected_count", del_q.size(), 1);
                end
            end
        end
    end

    initial begin
        int base;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        reset_w = 1'b1; req_ready_w = 1'b0; rsp_valid_w = 1'b0; rsp_data_w = 32'h0;
        stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 32'h0;

        // ---- wrap instance: RESET_PC = 0xFFFF_FFFC ----
        tick();
        check("w_reset_instr_pc", instr_pc_w, 32'hFFFF_FFFC);
        check("w_reset_addr",     addr_w,     32'hFFFF_FFFC);
        reset_w = 1'b0; req_ready_w = 1'b1;
        tick();
        check("w_req_valid", 32'(req_valid_w), 32'd1);
        check("w_req_addr",  addr_w,           32'hFFFF_FFFC);
        tick();
        req_ready_w = 1'b0; rsp_valid_w = 1'b1; rsp_data_w = 32'h0050_0093;
        tick();
        rsp_valid_w = 1'b0;
        check("w_instr_valid", 32'(instr_valid_w), 32'd1);
        check("w_instr",       instr_w,            32'h0050_0093);
        check("w_instr_pc",    instr_pc_w,         32'hFFFF_FFFC);
        check("w_pc_plus4",    pc_plus4_w,         32'h0);
        check("w_next_addr",   addr_w,             32'h0);

        // ---- main instance reset state ----
        check("rst_instr_valid", 32'(instr_valid),    32'd0);
        check("rst_instr",       instr,               32'h0000_0013);
        check("rst_instr_pc",    instr_pc,            32'h0);
        check("rst_req_valid",   32'(imem_req_valid), 32'd0);
        check("rst_addr",        imem_addr,           32'h0);
        check("rst_op",          32'(op),             32'h13);

        // ---- 1: basic fetch of two instructions ----
        budget = 2;
        req_q.push_back(32'h0); req_q.push_back(32'h4);
        del_q.push_back(mk(32'h0)); del_q.push_back(mk(32'h4));
        reset = 1'b0;
        #1 check("t1_no_req_first_cycle", 32'(imem_req_valid), 32'd0);
        repeat (10) tick();
        check("t1_drained", del_q.size(), 0);

        // ---- 2: response arrives behind a stall, parked in HOLD ----
        budget = 3;
        req_q.push_back(32'h8); req_q.push_back(32'hC); req_q.push_back(32'h10);
        del_q.push_back(mk(32'h8)); del_q.push_back(mk(32'hC)); del_q.push_back(mk(32'h10));
        wait_valid();
        stall = 1'b1;
        tick();
        tick();
        check("t2_hold_no_req",   32'(imem_req_valid), 32'd0);
        check("t2_hold_instr",    instr,               32'h00C0_0193);
        check("t2_hold_valid",    32'(instr_valid),    32'd1);
        tick();
        check("t2_hold_no_req2",  32'(imem_req_valid), 32'd0);
        check("t2_hold_instr_pc", instr_pc,            32'h8);
        stall = 1'b0;
        tick();
        check("t2_released_instr", instr,          32'h40B5_0533);
        check("t2_released_op",    32'(op),        32'h33);
        check("t2_released_f7b5",  32'(funct7b5),  32'd1);
        repeat (8) tick();

        // ---- 3: redirect while waiting for a response ----
        rsp_lat = 3;
        base = accept_cnt;
        budget = 1;
        req_q.push_back(32'h14);
        wait_accept(base);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        budget = 1;
        req_q.push_back(32'h100);
        del_q.push_back(mk(32'h100));
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_stale_dropped", 32'(instr_valid), 32'd0);
        end
        repeat (10) tick();

        // ---- 4: redirect in the same cycle the request is accepted ----
        rsp_lat = 1;
        base = accept_cnt;
        budget = 2;
        req_q.push_back(32'h104); req_q.push_back(32'h200);
        del_q.push_back(mk(32'h200));
        wait_accept(base);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();

        // ---- 5: redirect beats stall on a live output ----
        stall = 1'b1;
        budget = 1;
        req_q.push_back(32'h204);
        wait_valid();
        check("t5_loaded_instr", instr,    mem_word(32'h204));
        check("t5_loaded_pc",    instr_pc, 32'h204);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        check("t5_flush_valid", 32'(instr_valid), 32'd0);
        check("t5_flush_instr", instr,            32'h0000_0013);
        check("t5_new_addr",    imem_addr,        32'h300);
        stall = 1'b0;
        repeat (2) tick();

        // ---- 6: reset while in WAIT; the late response is a stray ----
        rsp_lat = 4;
        base = accept_cnt;
        budget = 1;
        req_q.push_back(32'h300);
        wait_accept(base);
        tick();
        reset = 1'b1;
        #1;
        check("t6_rst_req_valid",   32'(imem_req_valid), 32'd0);
        check("t6_rst_instr_valid", 32'(instr_valid),    32'd0);
        check("t6_rst_instr",       instr,               32'h0000_0013);
        check("t6_rst_instr_pc",    instr_pc,            32'h0);
        check("t6_rst_addr",        imem_addr,           32'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t6_stray_ignored", 32'(instr_valid), 32'd0);
        end
        check("t6_addr_after", imem_addr, 32'h0);

        repeat (2) tick();
        check("req_q_empty", req_q.size(), 0);
        check("del_q_empty", del_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
